// File: rtl/fp_pkg.sv
// Shared binary32 constants, flag indices and the packed result type for the
// normalize/round back end.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_INX = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Result class carried down the pipeline alongside the datapath.
    typedef enum logic [1:0] {
        K_NORM,
        K_ZERO,
        K_SPECIAL,
        K_FLUSH
    } kind_t;

endpackage

// File: rtl/fp_norm_round_lzc27.sv
// Combinational leading-zero counter over 27 bits; count is 27 when the
// input is all zero.
module fpnorm_lzc27 (
    input  logic [26:0] d,
    output logic [4:0]  count,
    output logic        zero
);

    always_comb begin
        count = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (d[i]) count = 5'(26 - i);
        end
    end

    assign zero = (d == '0);

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage normalize / round-to-nearest-even / pack back end for binary32.
// Define FPNORM_DENORMAL_EN to produce subnormals instead of flushing to zero.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: classify ----------------
    logic [27:0]       w_in;
    logic [4:0]        lz;
    logic              lz_zero;
    kind_t             s1_kind_d;
    logic signed [9:0] s1_exp_d;

    assign w_in = {in_mant, in_grs};

    fpnorm_lzc27 u_lzc (
        .d     (w_in[26:0]),
        .count (lz),
        .zero  (lz_zero)
    );

    always_comb begin
        s1_kind_d = K_NORM;
        s1_exp_d  = '0;
        if (in_exp == 8'(EXP_MAX))
            s1_kind_d = K_SPECIAL;
        else if (lz_zero && !in_mant[24])
            s1_kind_d = K_ZERO;
        else if (in_mant[24])
            s1_exp_d = $signed({2'b00, in_exp}) + 10'sd1;
        else
            s1_exp_d = $signed({2'b00, in_exp}) - $signed({5'b00000, lz});
    end

    logic              s1_valid;
    kind_t             s1_kind;
    logic              s1_sign;
    logic [27:0]       s1_w;
    logic signed [9:0] s1_exp;
    logic [4:0]        s1_lz;
    logic              s1_carry;
`ifdef FPNORM_DENORMAL_EN
    logic [7:0]        s1_in_exp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_kind   <= K_NORM;
            s1_sign   <= 1'b0;
            s1_w      <= '0;
            s1_exp    <= '0;
            s1_lz     <= '0;
            s1_carry  <= 1'b0;
`ifdef FPNORM_DENORMAL_EN
            s1_in_exp <= '0;
`endif
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_kind   <= s1_kind_d;
            s1_sign   <= in_sign;
            s1_w      <= w_in;
            s1_exp    <= s1_exp_d;
            s1_lz     <= lz;
            s1_carry  <= in_mant[24];
`ifdef FPNORM_DENORMAL_EN
            s1_in_exp <= in_exp;
`endif
        end
    end

    // ---------------- stage 2: shift ----------------
    logic [26:0]       w_sh;
    kind_t             s2_kind_d;
    logic signed [9:0] s2_exp_d;
    logic              tiny;

    always_comb begin
        tiny      = (s1_kind == K_NORM) && !s1_carry && (s1_exp < 10'sd1);
        s2_kind_d = s1_kind;
        s2_exp_d  = s1_exp;
        if (s1_kind != K_NORM) begin
            w_sh = s1_w[26:0];
        end else if (s1_carry) begin
            w_sh = {s1_w[27:2], s1_w[1] | s1_w[0]};
        end else if (tiny) begin
`ifdef FPNORM_DENORMAL_EN
            // Hidden-bit slot now weighs 2^-126, so exponent 1 with a 0 hidden bit.
            s2_exp_d = 10'sd1;
            if (s1_in_exp == '0)
                w_sh = {s1_w[27:2], s1_w[1] | s1_w[0]};
            else
                w_sh = 27'(s1_w << (s1_in_exp - 8'd1));
`else
            s2_kind_d = K_FLUSH;
            w_sh      = s1_w[26:0];
`endif
        end else begin
            w_sh = 27'(s1_w << s1_lz);
        end
    end

    logic              s2_valid;
    kind_t             s2_kind;
    logic              s2_sign;
    logic [23:0]       s2_sig;
    logic              s2_g, s2_r, s2_s;
    logic signed [9:0] s2_exp;
    logic              s2_tiny;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_kind  <= K_NORM;
            s2_sign  <= 1'b0;
            s2_sig   <= '0;
            s2_g     <= 1'b0;
            s2_r     <= 1'b0;
            s2_s     <= 1'b0;
            s2_exp   <= '0;
            s2_tiny  <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_kind  <= s2_kind_d;
            s2_sign  <= s1_sign;
            s2_sig   <= w_sh[26:3];
            s2_g     <= w_sh[2];
            s2_r     <= w_sh[1];
            s2_s     <= w_sh[0];
            s2_exp   <= s2_exp_d;
            s2_tiny  <= tiny;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic              inexact;
    logic              rnd_inc;
    logic [24:0]       rnd_sum;
    logic [23:0]       sig_r;
    logic signed [9:0] exp_r;
    fp32_t             res;
    logic [2:0]        flags;

    always_comb begin
        inexact = s2_g | s2_r | s2_s;
        rnd_inc = s2_g & (s2_r | s2_s | s2_sig[0]);
        rnd_sum = {1'b0, s2_sig} + {24'b0, rnd_inc};
        sig_r   = rnd_sum[24] ? rnd_sum[24:1] : rnd_sum[23:0];
        exp_r   = rnd_sum[24] ? s2_exp + 10'sd1 : s2_exp;
        res.sign = s2_sign;
        res.exp  = '0;
        res.frac = '0;
        flags    = '0;
        unique case (s2_kind)
            K_SPECIAL: begin
                res.exp  = '1;
                res.frac = s2_sig[22:0];
            end
            K_ZERO: ;
            K_FLUSH: begin
                flags[FLG_UNF] = 1'b1;
                flags[FLG_INX] = 1'b1;
            end
            default: begin
                if (exp_r >= $signed(10'(EXP_MAX))) begin
                    res.exp        = '1;
                    flags[FLG_OVF] = 1'b1;
                    flags[FLG_INX] = 1'b1;
                end else begin
                    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
                    res.exp        = sig_r[23] ? exp_r[7:0] : '0;
                    res.frac       = sig_r[22:0];
                    flags[FLG_INX] = inexact;
                    flags[FLG_UNF] = s2_tiny & inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= res;
                out_flags  <= flags;
            end
        end
    end

endmodule
